// File: rtl/assembler_pass_sequencer_if.sv
// assembler_pass_sequencer_if: assembler state type plus the sequencer's text, stream and status bundle.
package assembler_pass_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, PC_MAPPING, ASSEMBLING} assembler_state_t;
endpackage

interface assembler_pass_sequencer_if #(
  parameter int NUMBER_LINES = 256,
  parameter int TEXT_DEPTH = 4096
);
  logic start_in;
  logic [$clog2(TEXT_DEPTH):0] text_len_in;
  logic [$clog2(TEXT_DEPTH)-1:0] text_addr_out;
  logic [7:0] text_data_in;
  logic [7:0] character_out;
  logic new_character_out;
  logic new_line_out;
  logic valid_data_out;
  logic [$clog2(NUMBER_LINES)+1:0] pc_out;
  assembler_pass_sequencer_pkg::assembler_state_t assembler_state_out;
  logic error_in;
  logic busy_out;
  logic done_out;
  logic error_out;
  logic [$clog2(NUMBER_LINES)-1:0] error_line_out;
  modport master (
    input start_in, text_len_in, text_data_in, error_in,
    output text_addr_out, character_out, new_character_out, new_line_out, valid_data_out, pc_out,
      assembler_state_out, busy_out, done_out, error_out, error_line_out
  );
  modport slave (
    output start_in, text_len_in, text_data_in, error_in,
    input text_addr_out, character_out, new_character_out, new_line_out, valid_data_out, pc_out,
      assembler_state_out, busy_out, done_out, error_out, error_line_out
  );
endinterface

// File: rtl/assembler_pass_sequencer.sv
// assembler_pass_sequencer: two-pass character streamer with byte PC and error halt; COMMENT_SKIP_EN suppresses '/' comments.
module assembler_pass_sequencer
  import assembler_pass_sequencer_pkg::*;
#(
  parameter int NUMBER_LINES = 256,
  parameter int TEXT_DEPTH = 4096
) (
  input logic clk_in,
  input logic rst_in,
  assembler_pass_sequencer_if.master bus
);
  localparam int AW = $clog2(TEXT_DEPTH);
  localparam int LW = $clog2(NUMBER_LINES);
  localparam int PW = LW + 2;
  localparam logic [AW:0] DEPTH = (AW+1)'(TEXT_DEPTH);
  localparam logic [LW-1:0] LAST = LW'(NUMBER_LINES - 1);
`ifdef COMMENT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_EOL, S_SWITCH, S_DONE, S_ERROR} state_t;
  state_t state, state_n;
  assembler_state_t astate, astate_n;
  logic [AW:0] idx, idx_n, len, len_n;
  logic [PW-1:0] pc, pc_n;
  logic [LW-1:0] line, line_n, err_line, err_line_n;
  logic [7:0] chr, chr_n, d;
  logic pass2, pass2_n, in_label, in_label_n, content, content_n, open, open_n, in_cmt, in_cmt_n;
  logic new_chr, new_chr_n, new_line, new_line_n, valid, valid_n, busy, busy_n, done, done_n, err, err_n;
  logic alpha, cmt, running, at_end, fail;
  assign d = bus.text_data_in;
  assign alpha = (d >= 8'h41 && d <= 8'h5A) || (d >= 8'h61 && d <= 8'h7A);
  assign cmt = in_cmt || (SKIP && d == 8'h2F);
  assign running = state inside {S_FETCH, S_ISSUE, S_GAP, S_EOL, S_SWITCH};
  assign at_end = idx == len;
  assign fail = running && (bus.error_in || (state == S_EOL && line == LAST));
  // The RAM is addressed with the next index so its data is already valid in the FETCH cycle.
  assign bus.text_addr_out = idx_n[AW-1:0];
  assign bus.character_out = chr;
  assign bus.new_character_out = new_chr;
  assign bus.new_line_out = new_line;
  assign bus.valid_data_out = valid;
  assign bus.pc_out = pc;
  assign bus.assembler_state_out = astate;
  assign bus.busy_out = busy;
  assign bus.done_out = done;
  assign bus.error_out = err;
  assign bus.error_line_out = err_line;
  always_comb begin
    state_n = state;
    astate_n = astate;
    idx_n = idx;
    len_n = len;
    pc_n = pc;
    line_n = line;
    err_line_n = err_line;
    chr_n = chr;
    pass2_n = pass2;
    in_label_n = in_label;
    content_n = content;
    open_n = open;
    in_cmt_n = in_cmt;
    new_chr_n = 1'b0;
    new_line_n = 1'b0;
    valid_n = valid;
    busy_n = busy;
    done_n = 1'b0;
    err_n = err;
    if (fail) begin
      state_n = S_ERROR;
      astate_n = IDLE;
      err_line_n = line;
      valid_n = 1'b0;
      busy_n = 1'b0;
      err_n = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (bus.start_in) begin
            state_n = S_FETCH;
            astate_n = PC_MAPPING;
            len_n = bus.text_len_in > DEPTH ? DEPTH : bus.text_len_in;
            idx_n = '0;
            pc_n = '0;
            line_n = '0;
            pass2_n = 1'b0;
            in_label_n = 1'b0;
            content_n = 1'b0;
            open_n = 1'b0;
            in_cmt_n = 1'b0;
            valid_n = 1'b1;
            busy_n = 1'b1;
            err_n = 1'b0;
          end
        S_FETCH:
          // A synthetic newline closes the text only when the last line is still open.
          if (at_end) begin
            state_n = open ? S_EOL : S_SWITCH;
            new_line_n = open;
            valid_n = open;
          end else if (d == 8'h0A) begin
            state_n = S_EOL;
            new_line_n = 1'b1;
          end else if (d == 8'h0D) begin
            idx_n = idx + 1'b1;
          end else if (cmt) begin
            state_n = S_GAP;
            in_cmt_n = 1'b1;
            open_n = 1'b1;
          end else begin
            state_n = S_ISSUE;
            chr_n = d;
            new_chr_n = 1'b1;
            open_n = 1'b1;
            in_label_n = in_label ^ (d == 8'h2E);
            content_n = content | (alpha & ~in_label);
          end
        S_ISSUE: state_n = S_GAP;
        S_GAP: begin
          state_n = S_FETCH;
          idx_n = idx + 1'b1;
        end
        S_EOL: begin
          state_n = at_end ? S_SWITCH : S_FETCH;
          valid_n = !at_end;
          idx_n = at_end ? idx : idx + 1'b1;
          pc_n = content ? pc + PW'(4) : pc;
          line_n = line + 1'b1;
          in_label_n = 1'b0;
          content_n = 1'b0;
          open_n = 1'b0;
          in_cmt_n = 1'b0;
        end
        S_SWITCH:
          if (pass2) begin
            state_n = S_DONE;
            astate_n = IDLE;
            done_n = 1'b1;
            busy_n = 1'b0;
          end else begin
            state_n = S_FETCH;
            astate_n = ASSEMBLING;
            pass2_n = 1'b1;
            idx_n = '0;
            pc_n = '0;
            line_n = '0;
            valid_n = 1'b1;
          end
        default: state_n = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      state <= S_IDLE;
      astate <= IDLE;
      idx <= '0;
      len <= '0;
      pc <= '0;
      line <= '0;
      err_line <= '0;
      chr <= '0;
      pass2 <= 1'b0;
      in_label <= 1'b0;
      content <= 1'b0;
      open <= 1'b0;
      in_cmt <= 1'b0;
      new_chr <= 1'b0;
      new_line <= 1'b0;
      valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      astate <= astate_n;
      idx <= idx_n;
      len <= len_n;
      pc <= pc_n;
      line <= line_n;
      err_line <= err_line_n;
      chr <= chr_n;
      pass2 <= pass2_n;
      in_label <= in_label_n;
      content <= content_n;
      open <= open_n;
      in_cmt <= in_cmt_n;
      new_chr <= new_chr_n;
      new_line <= new_line_n;
      valid <= valid_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
    end
endmodule

// File: tb/tb_assembler_pass_sequencer.sv
// tb_assembler_pass_sequencer: directed and randomized two-pass runs checked against a line-level reference model.
`timescale 1ns/1ps
module tb_assembler_pass_sequencer;
  import assembler_pass_sequencer_pkg::*;
  localparam int NL = 8;
  localparam int TD = 64;
`ifdef COMMENT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic [7:0] text [TD];
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$], got_q[$], exp_sw[$], got_sw[$], chr_t[$];
  bit exp_err;
  int exp_eline;
  int dones, lowv, strk;
  string pool;
  assembler_pass_sequencer_if #(.NUMBER_LINES(NL), .TEXT_DEPTH(TD)) bus ();
  assembler_pass_sequencer #(.NUMBER_LINES(NL), .TEXT_DEPTH(TD)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) bus.text_data_in <= text[bus.text_addr_out];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ev(int st, int nl, int pc, int c);
    return (st << 16) | (nl << 15) | (pc << 8) | c;
  endfunction

  function automatic logic [7:0] conv(logic [7:0] b);
    return (b == 8'h7E) ? 8'h0D : b;
  endfunction

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) text[i] = conv(s[i]);
  endtask

  // Expected strobe sequence of both passes, walked line by line over the source text.
  task automatic model(input int n);
    exp_q.delete();
    exp_sw.delete();
    exp_err = 0;
    exp_eline = 0;
    for (int p = 1; p <= 2 && !exp_err; p++) begin
      int pc, ln;
      bit content, label, cmt, open;
      logic [7:0] c;
      pc = 0; ln = 0; content = 0; label = 0; cmt = 0; open = 0;
      for (int i = 0; i <= n && !exp_err; i++) begin
        if (i == n && !open) break;
        c = (i == n) ? 8'h0A : text[i];
        if (c == 8'h0A) begin
          exp_q.push_back(ev(p, 1, pc, 0));
          if (ln == NL - 1) begin
            exp_err = 1;
            exp_eline = ln;
          end
          if (content) pc = (pc + 4) % (4 * NL);
          ln++; content = 0; label = 0; cmt = 0; open = 0;
        end else if (c != 8'h0D) begin
          open = 1;
          if (SKIP && (cmt || c == 8'h2F)) cmt = 1;
          else begin
            exp_q.push_back(ev(p, 0, pc, int'(c)));
            if (!label && ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A))) content = 1;
            if (c == 8'h2E) label = !label;
          end
        end
      end
      if (!exp_err) exp_sw.push_back(pc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".flags"}, int'({bus.busy_out, bus.valid_data_out, bus.done_out, bus.error_out,
                                 bus.new_character_out, bus.new_line_out}), 0);
    check({tag, ".pc"}, int'(bus.pc_out), 0);
    check({tag, ".char"}, int'(bus.character_out), 0);
    check({tag, ".eline"}, int'(bus.error_line_out), 0);
    check({tag, ".state"}, int'(bus.assembler_state_out), int'(IDLE));
  endtask

  // err_at >= 0 raises error_in while pass 1 issues a character of that line.
  task automatic run(input string tag, input int n, input int len_in, input int err_at);
    int t, lines, t_inj;
    bit prev;
    got_q.delete(); got_sw.delete(); chr_t.delete();
    dones = 0; lowv = 0; strk = 0; lines = 0; prev = 0; t_inj = -1;
    model(n);
    @(negedge clk_in);
    bus.text_len_in = 7'(len_in);
    bus.start_in = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    for (t = 1; t < 4000; t++) begin
      if (bus.new_character_out) begin
        got_q.push_back(ev(int'(bus.assembler_state_out), 0, int'(bus.pc_out), int'(bus.character_out)));
        chr_t.push_back(t);
        if (prev) strk++;
        if (err_at == lines && bus.assembler_state_out == PC_MAPPING && t_inj < 0) begin
          bus.error_in = 1'b1;
          t_inj = t;
        end
      end
      if (bus.new_line_out) begin
        got_q.push_back(ev(int'(bus.assembler_state_out), 1, int'(bus.pc_out), 0));
        if (bus.assembler_state_out == PC_MAPPING) lines++;
        if (bus.new_character_out) strk++;
      end
      if (bus.busy_out && !bus.valid_data_out) begin
        got_sw.push_back(int'(bus.pc_out));
        if (bus.assembler_state_out == PC_MAPPING) lowv++;
      end
      prev = bus.new_character_out;
      if (bus.done_out) dones++;
      if (bus.done_out || bus.error_out) break;
      @(negedge clk_in);
    end
    bus.error_in = 1'b0;
    check({tag, ".finished"}, int'(t < 4000), 1);
    check({tag, ".strobes"}, strk, 0);
    if (err_at >= 0) begin
      check({tag, ".err"}, int'(bus.error_out), 1);
      check({tag, ".err_lat"}, t - t_inj, 1);
      check({tag, ".eline"}, int'(bus.error_line_out), err_at);
      check({tag, ".halt"}, int'({bus.valid_data_out, bus.busy_out}), 0);
      check({tag, ".nodone"}, dones, 0);
    end else begin
      check({tag, ".nevents"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check($sformatf("%s.ev%0d", tag, i), got_q[i], exp_q[i]);
      if (exp_err) begin
        check({tag, ".ovf_err"}, int'(bus.error_out), 1);
        check({tag, ".ovf_line"}, int'(bus.error_line_out), exp_eline);
        check({tag, ".ovf_nodone"}, dones, 0);
      end else begin
        check({tag, ".done"}, dones, 1);
        check({tag, ".noerr"}, int'(bus.error_out), 0);
        check({tag, ".idle"}, int'(bus.assembler_state_out), int'(IDLE));
        check({tag, ".turn"}, lowv, 1);
        check({tag, ".nsw"}, got_sw.size(), exp_sw.size());
        for (int i = 0; i < exp_sw.size() && i < got_sw.size(); i++)
          check($sformatf("%s.swpc%0d", tag, i), got_sw[i], exp_sw[i]);
        @(negedge clk_in);
        check({tag, ".done_pulse"}, int'(bus.done_out), 0);
      end
    end
  endtask

  initial begin
    int t, n, cnt;
    pool = "abcdXY..  /,1\n\n\n~";
    bus.start_in = 1'b0;
    bus.error_in = 1'b0;
    bus.text_len_in = '0;
    for (int i = 0; i < TD; i++) text[i] = 8'h7A;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_zero("reset");

    load("add\n");
    run("add", 4, 4, -1);
    check("add.first", chr_t.size() > 0 ? chr_t[0] : -1, 2);
    check("add.spacing", chr_t.size() > 1 ? chr_t[1] - chr_t[0] : -1, 3);

    load(".lp.\nadd\nbeq\n");
    run("label", 13, 13, -1);
    check("label.pc1", got_sw.size() > 0 ? got_sw[0] : -1, 8);

    load("add\nsub\nbeq\n");
    run("errin", 12, 12, 2);
    run("restart", 12, 12, -1);

    load("x~\ny");
    run("crlf", 4, 4, -1);
    check("crlf.pc1", got_sw.size() > 0 ? got_sw[0] : -1, 8);

    load("add /c\n");
    run("cmt", 7, 7, -1);
    cnt = 0;
    foreach (got_q[i]) if ((got_q[i] >> 15) == 2) cnt++;
    check("cmt.chars", cnt, SKIP ? 4 : 6);

    load("a\na\na\na\na\na\na\na\n");
    run("ovf", 16, 16, -1);
    check("ovf.line", int'(bus.error_line_out), NL - 1);

    for (int i = 0; i < TD; i++) text[i] = conv(pool[$urandom_range(0, pool.len() - 1)]);
    run("clamp", TD, 100, -1);

    load("add\nsub\n");
    @(negedge clk_in);
    bus.text_len_in = 7'd8;
    bus.start_in = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    for (t = 0; t < 300 && bus.assembler_state_out != ASSEMBLING; t++) @(negedge clk_in);
    check("midrst.reach", int'(t < 300), 1);
    repeat (4) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    check_zero("midrst");
    dones = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (bus.done_out) dones++;
    end
    check("midrst.nodone", dones, 0);

    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(0, 24);
      for (int i = 0; i < TD; i++) text[i] = conv(pool[$urandom_range(0, pool.len() - 1)]);
      run($sformatf("rnd%0d", r), n, n, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
